// File: rtl/id_stage.sv
// RV32I/RV32E decode stage: decodes OP-IMM, OP, LUI and AUIPC into ALU operands and
// controls, with a pending-write scoreboard that stalls issue on RAW/WAW hazards.
module id_stage #(
    parameter bit RV32E = 1'b0,
    parameter int NREG  = RV32E ? 16 : 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    output logic [4:0]  rs1_addr_o,
    output logic [4:0]  rs2_addr_o,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic        flush_i,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [3:0]  alu_op_o,
    output logic [4:0]  rd_addr_o,
    output logic        reg_wen_o,
    output logic        illegal_o
);
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                           ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_OR = 4'd8, ALU_AND = 4'd9;

    // Bits outside the implemented register file (and x0) can never become pending.
    localparam logic [31:0] PEND_MASK =
        ((NREG >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NREG) - 32'd1)) & 32'hFFFF_FFFE;

    function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic logic pend_hit(input logic [31:0] pend, input logic [4:0] idx);
        return (idx != 5'd0) && pend[idx];
    endfunction

    logic [6:0]         opcode;
    logic [2:0]         f3;
    logic [6:0]         f7;
    logic [4:0]         rs1_idx, rs2_idx, rd_idx;
    logic signed [31:0] imm_i_s;
    logic [31:0]        imm_u, shamt_z;

    assign opcode  = inst_i[6:0];
    assign rd_idx  = inst_i[11:7];
    assign f3      = inst_i[14:12];
    assign rs1_idx = inst_i[19:15];
    assign rs2_idx = inst_i[24:20];
    assign f7      = inst_i[31:25];
    assign imm_i_s = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_u   = {inst_i[31:12], 12'b0};
    assign shamt_z = {27'b0, inst_i[24:20]};

    logic        use_rs1, use_rs2, use_rd;
    logic        ill_p0, wen_p0;
    logic [31:0] op1_p0, op2_p0;
    logic [3:0]  alu_p0;
    logic [4:0]  rd_p0;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        ill_p0  = 1'b1;
        op1_p0  = 32'd0;
        op2_p0  = 32'd0;
        alu_p0  = ALU_ADD;
        case (opcode)
            OPC_OPIMM: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                op1_p0  = rs1_data_i;
                op2_p0  = imm_i_s;
                alu_p0  = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
                ill_p0  = 1'b0;
                if (f3 == 3'b001) begin
                    op2_p0 = shamt_z;
                    ill_p0 = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    op2_p0 = shamt_z;
                    ill_p0 = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
            end
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                op1_p0  = rs1_data_i;
                op2_p0  = rs2_data_i;
                alu_p0  = alu_from_f3(f3, f7[5]);
                ill_p0  = !((f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_LUI: begin
                use_rd = 1'b1;
                op2_p0 = imm_u;
                ill_p0 = 1'b0;
            end
            OPC_AUIPC: begin
                use_rd = 1'b1;
                op1_p0 = inst_addr_i;
                op2_p0 = imm_u;
                ill_p0 = 1'b0;
            end
            default: ;
        endcase
        if (RV32E && ((use_rs1 && rs1_idx[4]) || (use_rs2 && rs2_idx[4]) || (use_rd && rd_idx[4])))
            ill_p0 = 1'b1;
        rd_p0  = use_rd ? rd_idx : 5'd0;
        wen_p0 = use_rd && (rd_idx != 5'd0) && !ill_p0;
        if (ill_p0) begin
            op1_p0 = 32'd0;
            op2_p0 = 32'd0;
            alu_p0 = ALU_ADD;
            rd_p0  = 5'd0;
        end
    end

    assign rs1_addr_o = use_rs1 ? rs1_idx : 5'd0;
    assign rs2_addr_o = use_rs2 ? rs2_idx : 5'd0;

    logic        vld_p1, wen_p1;
    logic [31:0] pend_p1, pend_nxt;
    logic [4:0]  rd_p1;
    logic        hazard, accept;

    // Illegal instructions read nothing, so they never wait on the scoreboard.
    assign hazard = (!ill_p0 && use_rs1 && pend_hit(pend_p1, rs1_idx)) |
                    (!ill_p0 && use_rs2 && pend_hit(pend_p1, rs2_idx)) |
                    (wen_p0 && pend_hit(pend_p1, rd_idx));
    assign in_ready = (!vld_p1 || out_ready) && !hazard && !flush_i;
    assign accept   = in_valid && in_ready;

    always_comb begin
        pend_nxt = pend_p1;
        if (wb_en_i)
            pend_nxt[wb_addr_i] = 1'b0;
        if (flush_i && vld_p1 && wen_p1)
            pend_nxt[rd_p1] = 1'b0;
        if (accept && wen_p0)
            pend_nxt[rd_p0] = 1'b1;
        pend_nxt = pend_nxt & PEND_MASK;
    end

    // Stage boundary: decoded instruction into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            pend_p1     <= 32'd0;
            inst_o      <= 32'd0;
            inst_addr_o <= 32'd0;
            op1_o       <= 32'd0;
            op2_o       <= 32'd0;
            alu_op_o    <= 4'd0;
            rd_p1       <= 5'd0;
            wen_p1      <= 1'b0;
            illegal_o   <= 1'b0;
        end else begin
            pend_p1 <= pend_nxt;
            if (accept) begin
                vld_p1      <= 1'b1;
                inst_o      <= inst_i;
                inst_addr_o <= inst_addr_i;
                op1_o       <= op1_p0;
                op2_o       <= op2_p0;
                alu_op_o    <= alu_p0;
                rd_p1       <= rd_p0;
                wen_p1      <= wen_p0;
                illegal_o   <= ill_p0;
            end else if (flush_i || out_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign rd_addr_o = rd_p1;
    assign reg_wen_o = wen_p1;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push expected decode results,
// a negedge monitor pops and compares on every output handshake.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, e_in_valid = 1'b0;
    logic        in_ready, e_in_ready;
    logic [31:0] inst_i = 32'd0, inst_addr_i = 32'd0;
    logic [31:0] rs1_data_i = 32'd0, rs2_data_i = 32'd0;
    logic [4:0]  rs1_addr_o, rs2_addr_o, e_rs1_addr, e_rs2_addr;
    logic        wb_en_i = 1'b0;
    logic [4:0]  wb_addr_i = 5'd0;
    logic        flush_i = 1'b0;
    logic        out_valid, e_out_valid;
    logic        out_ready = 1'b1, e_out_ready = 1'b1;
    logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
    logic [31:0] e_inst, e_addr, e_op1, e_op2;
    logic [3:0]  alu_op_o, e_alu;
    logic [4:0]  rd_addr_o, e_rd;
    logic        reg_wen_o, illegal_o, e_wen, e_ill;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct packed {
        logic [31:0] inst, addr, op1, op2;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        wen, ill;
    } exp_t;
    exp_t q[$];

    id_stage #(.RV32E(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
        .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready), .inst_o(inst_o),
        .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o), .alu_op_o(alu_op_o),
        .rd_addr_o(rd_addr_o), .reg_wen_o(reg_wen_o), .illegal_o(illegal_o)
    );

    id_stage #(.RV32E(1'b1)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .in_valid(e_in_valid), .in_ready(e_in_ready),
        .inst_i(inst_i), .inst_addr_i(inst_addr_i), .rs1_addr_o(e_rs1_addr), .rs2_addr_o(e_rs2_addr),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i),
        .flush_i(1'b0), .out_valid(e_out_valid), .out_ready(e_out_ready), .inst_o(e_inst),
        .inst_addr_o(e_addr), .op1_o(e_op1), .op2_o(e_op2), .alu_op_o(e_alu),
        .rd_addr_o(e_rd), .reg_wen_o(e_wen), .illegal_o(e_ill)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] inst, addr, op1, op2, input logic [3:0] alu,
                                input logic [4:0] rd, input logic wen, ill);
        exp_t e;
        e.inst = inst; e.addr = addr; e.op1 = op1; e.op2 = op2;
        e.alu = alu; e.rd = rd; e.wen = wen; e.ill = ill;
        return e;
    endfunction

    // Call just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] inst, addr, d1, d2, input exp_t e);
        int n;
        in_valid = 1'b1; inst_i = inst; inst_addr_i = addr;
        rs1_data_i = d1; rs2_data_i = d2;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check1("issue_in_ready", in_ready, 1'b1);
        if (in_ready) begin
            q.push_back(e);
            acc_cyc = cyc;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Monitor: every output handshake consumes one expected entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !flush_i) begin
            if (q.size() == 0) begin
                check("unexpected_output", inst_o, 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("inst_o", inst_o, e.inst);
                check("inst_addr_o", inst_addr_o, e.addr);
                check("op1_o", op1_o, e.op1);
                check("op2_o", op2_o, e.op2);
                check("ctl{alu,rd,wen,ill}", {21'd0, alu_op_o, rd_addr_o, reg_wen_o, illegal_o},
                      {21'd0, e.alu, e.rd, e.wen, e.ill});
            end
        end
    end

    int c0, wb_cyc, fl_cyc;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check("rst_inst_o", inst_o, 32'd0);
        check("rst_op2_o", op2_o, 32'd0);
        check("rst_ctl", {21'd0, alu_op_o, rd_addr_o, reg_wen_o, illegal_o}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADDI x1,x0,-5 then dependent ADD x2,x1,x1
        issue(32'hFFB00093, 32'h0, 32'h0, 32'h0, mk(32'hFFB00093, 32'h0, 32'h0, 32'hFFFF_FFFB, 4'd0, 5'd1, 1'b1, 1'b0));
        check1("latency_out_valid", out_valid, 1'b1);
        in_valid = 1'b1; inst_i = 32'h00108133; inst_addr_i = 32'h4;
        rs1_data_i = 32'hFFFF_FFFB; rs2_data_i = 32'hFFFF_FFFB;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check1("raw_stall", in_ready, 1'b0);
        end
        check({"rs_addrs"}, {22'd0, rs1_addr_o, rs2_addr_o}, {22'd0, 5'd1, 5'd1});
        @(posedge clk);
        #1 wb_en_i = 1'b1; wb_addr_i = 5'd1;
        @(negedge clk);
        check1("no_wb_bypass", in_ready, 1'b0);
        wb_cyc = cyc;
        @(posedge clk);
        #1 wb_en_i = 1'b0;
        issue(32'h00108133, 32'h4, 32'hFFFF_FFFB, 32'hFFFF_FFFB,
              mk(32'h00108133, 32'h4, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 4'd0, 5'd2, 1'b1, 1'b0));
        check("stall_release_cycle", acc_cyc, wb_cyc + 1);
        wb_en_i = 1'b1; wb_addr_i = 5'd2;
        @(posedge clk);
        #1 wb_en_i = 1'b0;

        // Back-to-back independent SUB, SRA, SRAI, SLTU, AND
        issue(32'h40C58533, 32'h10, 32'h8000_0001, 32'hF, mk(32'h40C58533, 32'h10, 32'h8000_0001, 32'hF, 4'd1, 5'd10, 1'b1, 1'b0));
        c0 = acc_cyc;
        issue(32'h40C5D6B3, 32'h14, 32'h8000_0001, 32'hF, mk(32'h40C5D6B3, 32'h14, 32'h8000_0001, 32'hF, 4'd7, 5'd13, 1'b1, 1'b0));
        issue(32'h41F5D713, 32'h18, 32'h8000_0001, 32'hF, mk(32'h41F5D713, 32'h18, 32'h8000_0001, 32'h1F, 4'd7, 5'd14, 1'b1, 1'b0));
        issue(32'h00C5B7B3, 32'h1C, 32'h8000_0001, 32'hF, mk(32'h00C5B7B3, 32'h1C, 32'h8000_0001, 32'hF, 4'd4, 5'd15, 1'b1, 1'b0));
        issue(32'h00C5F833, 32'h20, 32'h8000_0001, 32'hF, mk(32'h00C5F833, 32'h20, 32'h8000_0001, 32'hF, 4'd9, 5'd16, 1'b1, 1'b0));
        check("throughput_cycles", acc_cyc - c0, 32'd4);

        // LUI x3 / AUIPC x4 at 0x100
        inst_i = 32'h123451B7;
        #1 check("lui_rs1_addr_zero", {27'd0, rs1_addr_o}, 32'd0);
        issue(32'h123451B7, 32'hFC, 32'hAAAA_AAAA, 32'h5555_5555, mk(32'h123451B7, 32'hFC, 32'h0, 32'h1234_5000, 4'd0, 5'd3, 1'b1, 1'b0));
        issue(32'h00001217, 32'h100, 32'hAAAA_AAAA, 32'h5555_5555, mk(32'h00001217, 32'h100, 32'h100, 32'h1000, 4'd0, 5'd4, 1'b1, 1'b0));

        // Illegal opcode, bad funct7, ADDI x0
        issue(32'h0000007F, 32'h104, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h0000007F, 32'h104, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1));
        issue(32'h022083B3, 32'h108, 32'h1234_5678, 32'h9ABC_DEF0, mk(32'h022083B3, 32'h108, 32'h0, 32'h0, 4'd0, 5'd0, 1'b0, 1'b1));
        issue(32'h00500013, 32'h10C, 32'h0, 32'h0, mk(32'h00500013, 32'h10C, 32'h0, 32'h5, 4'd0, 5'd0, 1'b0, 1'b0));
        @(posedge clk);
        #1 out_ready = 1'b0;

        // Hold then flush ADDI x5
        issue(32'h00700293, 32'h110, 32'h0, 32'h0, mk(32'h00700293, 32'h110, 32'h0, 32'h7, 4'd0, 5'd5, 1'b1, 1'b0));
        inst_i = 32'h00700493;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check1("hold_out_valid", out_valid, 1'b1);
            check("hold_inst_o", inst_o, 32'h00700293);
            check("hold_op2_o", op2_o, 32'h7);
            check1("backpressure_in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #1 flush_i = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; inst_i = 32'h00528333;
        @(negedge clk);
        check1("flush_blocks_in_ready", in_ready, 1'b0);
        fl_cyc = cyc;
        void'(q.pop_front());
        @(posedge clk);
        #1 flush_i = 1'b0;
        check1("flush_out_valid", out_valid, 1'b0);
        issue(32'h00528333, 32'h114, 32'h11, 32'h22, mk(32'h00528333, 32'h114, 32'h11, 32'h22, 4'd0, 5'd6, 1'b1, 1'b0));
        check("flush_clears_pending", acc_cyc, fl_cyc + 1);

        // RV32E instance: x16 illegal, x8 legal
        out_ready = 1'b0;
        e_in_valid = 1'b1; inst_i = 32'h00208833; rs1_data_i = 32'h33; rs2_data_i = 32'h44;
        @(negedge clk);
        check1("e_in_ready", e_in_ready, 1'b1);
        @(posedge clk);
        #1 inst_i = 32'h00208433;
        @(negedge clk);
        check1("e_x16_out_valid", e_out_valid, 1'b1);
        check("e_x16_ctl", {22'd0, e_rd, e_wen, e_ill, e_alu}, {22'd0, 5'd0, 1'b0, 1'b1, 4'd0});
        check("e_x16_op1", e_op1, 32'h0);
        @(posedge clk);
        #1 e_in_valid = 1'b0;
        @(negedge clk);
        check("e_x8_ctl", {22'd0, e_rd, e_wen, e_ill, e_alu}, {22'd0, 5'd8, 1'b1, 1'b0, 4'd0});
        check("e_x8_op1", e_op1, 32'h33);

        // Reset mid-stall: ADD x6 held, ADD x7 waits on x6
        @(posedge clk);
        #1 in_valid = 1'b1; inst_i = 32'h006303B3;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check1("pre_reset_stall", in_ready, 1'b0);
        end
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check1("midrst_out_valid", out_valid, 1'b0);
        check("midrst_data", inst_o | op1_o | op2_o | inst_addr_o, 32'd0);
        check("midrst_ctl", {21'd0, alu_op_o, rd_addr_o, reg_wen_o, illegal_o}, 32'd0);
        check1("midrst_e_out_valid", e_out_valid, 1'b0);
        check1("midrst_scoreboard_empty", in_ready, 1'b1);
        q.delete();
        out_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(32'h006303B3, 32'h200, 32'h3, 32'h3, mk(32'h006303B3, 32'h200, 32'h3, 32'h3, 4'd0, 5'd7, 1'b1, 1'b0));

        for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Registered, flow-controlled RV32I/RV32E instruction decode stage between `if_id` and `ex`. It decodes OP-IMM, OP, LUI and AUIPC into ALU operands, an ALU opcode and writeback controls, and holds the result in an output register with valid/ready handshakes. A per-register pending-write scoreboard stalls issue on RAW and WAW hazards until writeback clears them. Flush kills the instruction held in the output register.

## Interface
- `RV32E`, default 0: 1 = 16-register mode; any rs1/rs2/rd index with bit 4 set is illegal.
- `NREG`, default 32 (16 when `RV32E`=1, derived): number of scoreboard entries.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: `inst_i`/`inst_addr_i` valid.
- `in_ready` out 1: instruction accepted this cycle when `in_valid`&`in_ready`.
- `inst_i` in 32: instruction word.
- `inst_addr_i` in 32: instruction address.
- `rs1_addr_o` out 5: regfile read address 1, combinational from `inst_i`.
- `rs2_addr_o` out 5: regfile read address 2, combinational from `inst_i`.
- `rs1_data_i` in 32: regfile read data 1, same cycle.
- `rs2_data_i` in 32: regfile read data 2, same cycle.
- `wb_en_i` in 1: writeback this cycle; clears pending bit of `wb_addr_i`.
- `wb_addr_i` in 5: writeback register index.
- `flush_i` in 1: kill the output-register contents.
- `out_valid` out 1: output register holds an instruction.
- `out_ready` in 1: downstream accepts when `out_valid`&`out_ready`.
- `inst_o`, `inst_addr_o` out 32 each: registered copies.
- `op1_o`, `op2_o` out 32 each: ALU operands.
- `alu_op_o` out 4: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
- `rd_addr_o` out 5: destination register.
- `reg_wen_o` out 1: write rd.
- `illegal_o` out 1: unsupported or malformed instruction.

## Operation
- Decode (combinational on `inst_i`):
  - OP-IMM (0010011): op1=rs1 data, op2=sign-extended imm[31:20].
  - SLLI/SRLI/SRAI: op2=zero-extended shamt. Require funct7 0000000 (SRAI 0100000), else illegal.
  - OP (0110011): op1/op2=rs1/rs2 data. funct7 0100000 allowed only for SUB/SRA; any other funct7 besides 0000000 is illegal.
  - LUI: op1=0, op2={imm[31:12],12'b0}, ADD.
  - AUIPC: op1=`inst_addr_i`, op2 as LUI, ADD.
  - rs addresses are 0 for fields the format does not use.
- Illegal instruction: `illegal_o`=1, `reg_wen_o`=0, op1/op2/rd/`alu_op_o`=0. Covers any other opcode, bad funct7, or RV32E index ≥16. It still passes through the handshake.
- `reg_wen_o`=1 for legal instructions with rd≠0; rd=0 gives `reg_wen_o`=0.
- Scoreboard: `NREG` pending bits; x0 is never pending.
- `hazard` = (used rs1 pending) | (used rs2 pending) | (reg_wen & rd pending). Pending bits are the registered values; there is no writeback bypass.
- `in_ready` = (!`out_valid` | `out_ready`) & !`hazard` & !`flush_i`.
- On accept: load the output register and set pending[rd] if reg_wen.
- Writeback: `wb_en_i` with `wb_addr_i`≠0 clears pending[`wb_addr_i`] at the clock edge.
- Set and clear never target the same bit in one cycle, because accept requires rd not pending.
- Flush: `out_valid`←0 next edge. If the killed entry had reg_wen, its pending bit is cleared. Set by the incoming instruction is suppressed, since `in_ready`=0. Older writebacks still clear normally.
- If `out_valid` & !`out_ready` & !`flush_i`, the output register holds.

## Timing
- Reset (async assert, sync-safe release): `out_valid`=0; all registered outputs 0; all pending bits 0.
- Latency: 1 cycle, accept at edge N → `out_valid` at N.
- Throughput: 1 per cycle with no hazard and `out_ready`=1.
- Stall: `in_ready` stays low while hazard persists; it rises in the cycle after the edge that clears the bit.
- Back-pressure: `out_ready`=0 with `out_valid`=1 → `in_ready`=0.
- `flush_i` and `out_ready` both high: flush wins and the entry is dropped.
- Reset mid-stall clears the scoreboard and drops the held instruction.

## Test plan
- Reset, then ADDI x1,x0,-5 (0xFFB00093), then ADD x2,x1,x1. Required:
  - Cycle 1: op2=0xFFFFFFFB, alu_op 0, rd 1, wen 1.
  - ADD stalls until `wb_en_i`/`wb_addr_i`=1, then issues one cycle later.
- SUB, SRA, SRAI, SLTU, AND back-to-back, independent registers, `out_ready`=1. Required: one issue per cycle, alu_op 1,7,7,4,9, shamt zero-extended.
- LUI x3,0x12345 and AUIPC x4,0x1 at addr 0x100. Required:
  - LUI: op2=0x12345000, op1=0.
  - AUIPC: op1=0x100, op2=0x1000.
- Opcode 0x7F, OP with funct7 0000001, and ADDI x0. Required:
  - First two: `illegal_o`=1, wen 0.
  - ADDI x0: legal, wen 0, no pending bit set.
- Hold `out_ready`=0 two cycles, then flush an ADDI x5 entry. Required:
  - Output stable while held.
  - After the flush, `out_valid`=0 and pending[5]=0, so a following ADD x6,x5,x5 issues immediately.
- `RV32E`=1: ADD x16,x1,x2. Required: `illegal_o`=1. Assert `rst_n` low mid-stall → all outputs 0 and the scoreboard empty.
